// File: rtl/ndn_pkg.sv
// Shared FIB-side constants and the transmit FSM state type.
package ndn_pkg;

  localparam int unsigned FIB_META_BYTES   = 1;
  localparam int unsigned FIB_PREFIX_BYTES = 8;
  localparam int unsigned FIB_TX_BYTES     = 17;
  localparam int unsigned FIB_TX_BITS      = 136;

  localparam int unsigned BYTE_CNT_W = 5;
  localparam int unsigned BIT_CNT_W  = 8;
  localparam int unsigned DIV_W      = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    SHIFT   = 2'd2,
    HOLD    = 2'd3
  } fib_tx_state_t;

endpackage

// File: rtl/spi_sclk_divider.sv
// SPI clock generator: CLK_DIV cycles per half-period, idles low while disabled.
module spi_sclk_divider
  import ndn_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic sclk,
  output logic rise_next,
  output logic fall_next
);

  localparam logic [DIV_W-1:0] TC = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             sclk_q, sclk_d;
  logic             tc_c;

  always_comb begin
    tc_c   = enable && (cnt_q == TC);
    cnt_d  = '0;
    sclk_d = 1'b0;
    if (enable) begin
      if (cnt_q == TC) begin
        cnt_d  = '0;
        sclk_d = ~sclk_q;
      end else begin
        cnt_d  = cnt_q + DIV_W'(1);
        sclk_d = sclk_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      sclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
    end
  end

  // Strobes announce the sclk edge that happens at the next clk edge.
  assign rise_next = tc_c & ~sclk_q;
  assign fall_next = tc_c & sclk_q;
  assign sclk      = sclk_q;

endmodule

// File: rtl/fib_spi_tx.sv
// Captures the 17-byte FIB interest burst and shifts it out MSB-first on an SPI mode-0 link.
module fib_spi_tx
  import ndn_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       FIB_to_SPI_data_flag,
  input  logic [7:0] data_FIB_to_SPI,
  output logic       spi_cs_n,
  output logic       spi_sclk,
  output logic       spi_mosi,
  output logic       busy,
  output logic       done,
  output logic       dropped
);

  localparam int unsigned     MSB     = FIB_TX_BITS - 1;
  localparam logic [DIV_W-1:0] HOLD_TC = DIV_W'(CLK_DIV - 1);

  fib_tx_state_t           state_q, state_d;
  logic [BYTE_CNT_W-1:0]   byte_cnt_q, byte_cnt_d;
  logic [BIT_CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [DIV_W-1:0]        hold_cnt_q, hold_cnt_d;
  logic [FIB_TX_BITS-1:0]  buf_q, buf_d;
  logic                    shift_en_q, shift_en_d;
  logic                    last_bit_q, last_bit_d;
  logic                    cs_n_q, cs_n_d;
  logic                    mosi_q, mosi_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    dropped_q, dropped_d;

  logic                    sclk_w;
  logic                    rise_next_w;
  logic                    fall_next_w;

  spi_sclk_divider #(
    .CLK_DIV (CLK_DIV)
  ) u_div (
    .clk       (clk),
    .rst       (rst),
    .enable    (shift_en_q),
    .sclk      (sclk_w),
    .rise_next (rise_next_w),
    .fall_next (fall_next_w)
  );

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    hold_cnt_d = hold_cnt_q;
    buf_d      = buf_q;
    shift_en_d = shift_en_q;
    last_bit_d = last_bit_q;
    cs_n_d     = cs_n_q;
    mosi_d     = mosi_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    dropped_d  = 1'b0;

    if (FIB_to_SPI_data_flag && (state_q != IDLE)) begin
      dropped_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (FIB_to_SPI_data_flag) begin
          state_d    = CAPTURE;
          byte_cnt_d = '0;
          busy_d     = 1'b1;
        end
      end

      CAPTURE: begin
        buf_d = {buf_q[MSB-8:0], data_FIB_to_SPI};
        if (byte_cnt_q == BYTE_CNT_W'(FIB_TX_BYTES - 1)) begin
          state_d    = SHIFT;
          bit_cnt_d  = BIT_CNT_W'(MSB);
          last_bit_d = 1'b0;
        end else begin
          byte_cnt_d = byte_cnt_q + BYTE_CNT_W'(1);
        end
      end

      SHIFT: begin
        if (!shift_en_q) begin
          // First SHIFT cycle: drop cs_n and present bit 135 before sclk starts.
          shift_en_d = 1'b1;
          cs_n_d     = 1'b0;
          mosi_d     = buf_q[MSB];
        end else begin
          // Decide "last bit" at the rising edge so the falling edge only tests a flop.
          if (rise_next_w) begin
            last_bit_d = (bit_cnt_q == '0);
          end
          if (fall_next_w) begin
            if (last_bit_q) begin
              state_d    = HOLD;
              shift_en_d = 1'b0;
              hold_cnt_d = '0;
            end else begin
              bit_cnt_d = bit_cnt_q - BIT_CNT_W'(1);
              buf_d     = {buf_q[MSB-1:0], 1'b0};
              mosi_d    = buf_q[MSB-1];
            end
          end
        end
      end

      HOLD: begin
        if (hold_cnt_q == HOLD_TC) begin
          state_d    = IDLE;
          cs_n_d     = 1'b1;
          mosi_d     = 1'b0;
          busy_d     = 1'b0;
          done_d     = 1'b1;
          last_bit_d = 1'b0;
        end else begin
          hold_cnt_d = hold_cnt_q + DIV_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      byte_cnt_q <= '0;
      bit_cnt_q  <= '0;
      hold_cnt_q <= '0;
      buf_q      <= '0;
      shift_en_q <= 1'b0;
      last_bit_q <= 1'b0;
      cs_n_q     <= 1'b1;
      mosi_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      dropped_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      buf_q      <= buf_d;
      shift_en_q <= shift_en_d;
      last_bit_q <= last_bit_d;
      cs_n_q     <= cs_n_d;
      mosi_q     <= mosi_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      dropped_q  <= dropped_d;
    end
  end

  assign spi_cs_n = cs_n_q;
  assign spi_sclk = sclk_w;
  assign spi_mosi = mosi_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign dropped  = dropped_q;

endmodule

// File: tb/tb_fib_spi_tx.sv
// Scoreboard bench for fib_spi_tx: stimulus queues expected bytes, an SPI monitor reassembles and checks them.
module tb_fib_spi_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flag = 1'b0;
  logic [7:0] data = 8'h00;
  logic       sel = 1'b0;

  logic s2_flag, s1_flag;
  logic cs2, sclk2, mosi2, busy2, done2, drop2;
  logic cs1, sclk1, mosi1, busy1, done1, drop1;
  logic m_cs_n, m_sclk, m_mosi, m_busy, m_done, m_dropped;

  assign s2_flag = !sel && flag;
  assign s1_flag = sel && flag;

  fib_spi_tx #(.CLK_DIV(2)) dut2 (
    .clk(clk), .rst(rst), .FIB_to_SPI_data_flag(s2_flag), .data_FIB_to_SPI(data),
    .spi_cs_n(cs2), .spi_sclk(sclk2), .spi_mosi(mosi2), .busy(busy2), .done(done2), .dropped(drop2)
  );

  fib_spi_tx #(.CLK_DIV(1)) dut1 (
    .clk(clk), .rst(rst), .FIB_to_SPI_data_flag(s1_flag), .data_FIB_to_SPI(data),
    .spi_cs_n(cs1), .spi_sclk(sclk1), .spi_mosi(mosi1), .busy(busy1), .done(done1), .dropped(drop1)
  );

  assign m_cs_n    = sel ? cs1   : cs2;
  assign m_sclk    = sel ? sclk1 : sclk2;
  assign m_mosi    = sel ? mosi1 : mosi2;
  assign m_busy    = sel ? busy1 : busy2;
  assign m_done    = sel ? done1 : done2;
  assign m_dropped = sel ? drop1 : drop2;

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [7:0] sb_q[$];
  int         xfer_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // SPI monitor: samples on the falling clk edge, away from the DUT's active edge.
  logic [7:0] sh;
  int         nb = 0, low_cnt = 0, mon_rise = 0, hi_chg = 0, drop_cnt = 0;
  logic       prev_cs_n = 1'b1, prev_sclk = 1'b0, prev_mosi = 1'b0, prev_busy = 1'b0;
  logic       first_bit = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      sh = 8'h00; nb = 0; low_cnt = 0; mon_rise = 0; hi_chg = 0;
      prev_cs_n = 1'b1; prev_sclk = 1'b0; prev_mosi = 1'b0; prev_busy = 1'b0;
    end else begin
      if (!m_cs_n) begin
        low_cnt++;
        if (m_sclk && m_mosi !== prev_mosi) hi_chg++;
        if (m_sclk && !prev_sclk) begin
          if (mon_rise == 0) first_bit = m_mosi;
          mon_rise++;
          sh = {sh[6:0], m_mosi};
          nb++;
          if (nb == 8) begin
            nb = 0;
            if (sb_q.size() == 0) chk("unexpected_spi_byte", {24'h0, sh}, 32'hFFFF_FFFF);
            else chk("spi_byte", {24'h0, sh}, {24'h0, sb_q.pop_front()});
          end
        end
      end
      if (m_dropped) drop_cnt++;
      if (m_cs_n && !prev_cs_n) begin
        if (xfer_q.size() == 0) chk("unexpected_transfer", 32'd1, 32'd0);
        else chk("cs_low_cycles", low_cnt, xfer_q.pop_front());
        chk("sclk_rises", mon_rise, 136);
        chk("done_with_cs_rise", {31'h0, m_done}, 32'd1);
        chk("busy_drops_with_cs", {30'h0, prev_busy, m_busy}, 32'd2);
        chk("mosi_change_while_sclk_high", hi_chg, 0);
        chk("partial_byte_bits", nb, 0);
        low_cnt = 0; mon_rise = 0; hi_chg = 0; nb = 0;
      end
      if (m_done) chk("done_alignment", {30'h0, prev_cs_n, m_cs_n}, 32'd1);
      prev_cs_n = m_cs_n; prev_sclk = m_sclk; prev_mosi = m_mosi; prev_busy = m_busy;
    end
  end

  task automatic send_burst(input logic [7:0] b [17], input int div);
    for (int i = 0; i < 17; i++) sb_q.push_back(b[i]);
    xfer_q.push_back(273 * div);
    @(negedge clk); flag = 1'b1; data = 8'h00;
    for (int i = 0; i < 17; i++) begin
      @(negedge clk); flag = 1'b0; data = b[i];
    end
    @(negedge clk); data = 8'h00;
  endtask

  task automatic wait_done(input int budget, input string nm);
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (m_done) break;
    end
    chk(nm, {31'h0, m_done}, 32'd1);
  endtask

  task automatic wait_rise(input int target, input int budget, input string nm);
    for (int n = 0; n < budget; n++) begin
      @(negedge clk); #1;
      if (mon_rise >= target) break;
    end
    chk(nm, {31'h0, (mon_rise >= target)}, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b [17];
    logic [7:0] b2 [17];
    int         drop0;
    int         fall_k;

    // Reset values on both instances.
    repeat (3) @(negedge clk);
    #3;
    chk("rst_cs_n_d2", {31'h0, cs2}, 1);   chk("rst_sclk_d2", {31'h0, sclk2}, 0);
    chk("rst_mosi_d2", {31'h0, mosi2}, 0); chk("rst_busy_d2", {31'h0, busy2}, 0);
    chk("rst_done_d2", {31'h0, done2}, 0); chk("rst_drop_d2", {31'h0, drop2}, 0);
    chk("rst_cs_n_d1", {31'h0, cs1}, 1);   chk("rst_sclk_d1", {31'h0, sclk1}, 0);
    chk("rst_mosi_d1", {31'h0, mosi1}, 0); chk("rst_busy_d1", {31'h0, busy1}, 0);
    @(negedge clk); #2; rst = 1'b0;

    // CLK_DIV=2 reference burst.
    b[0] = 8'h05;
    for (int i = 0; i < 8; i++) begin b[1+i] = 8'h11 + 8'(i); b[9+i] = 8'h21 + 8'(i); end
    send_burst(b, 2);
    wait_done(700, "wait_done_basic");
    repeat (5) @(negedge clk);

    // CLK_DIV=1 instance, all 0xA5.
    sel = 1'b1;
    for (int i = 0; i < 17; i++) b[i] = 8'hA5;
    send_burst(b, 1);
    wait_done(400, "wait_done_div1");
    chk("div1_first_bit", {31'h0, first_bit}, 1);
    repeat (3) @(negedge clk);
    sel = 1'b0;
    repeat (3) @(negedge clk);

    // Strobes during CAPTURE and at transfer bit 60 are dropped.
    drop0 = drop_cnt;
    for (int i = 0; i < 17; i++) b[i] = 8'h60 + 8'(i);
    for (int i = 0; i < 17; i++) sb_q.push_back(b[i]);
    xfer_q.push_back(546);
    @(negedge clk); flag = 1'b1;
    for (int i = 0; i < 17; i++) begin
      @(negedge clk); flag = (i == 5); data = b[i];
    end
    @(negedge clk); flag = 1'b0; data = 8'h00;
    wait_rise(76, 600, "reach_bit60");
    @(negedge clk); flag = 1'b1; data = 8'hEE;
    for (int i = 0; i < 17; i++) begin
      @(negedge clk); flag = 1'b0; data = 8'hEE;
    end
    data = 8'h00;
    wait_done(700, "wait_done_dropped");
    repeat (40) @(negedge clk);
    chk("no_second_transfer_cs", {31'h0, m_cs_n}, 1);
    chk("no_second_transfer_busy", {31'h0, m_busy}, 0);
    chk("dropped_pulses", drop_cnt - drop0, 2);

    // Back-to-back: strobe in the done cycle is accepted.
    for (int i = 0; i < 17; i++) begin b[i] = 8'h30 + 8'(i); b2[i] = 8'hC0 + 8'(i); end
    send_burst(b, 2);
    wait_done(700, "wait_done_b2b_first");
    for (int i = 0; i < 17; i++) sb_q.push_back(b2[i]);
    xfer_q.push_back(546);
    flag = 1'b1; data = 8'h00;
    fall_k = -1;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (k == 0) begin
        flag = 1'b0;
        chk("b2b_busy_next_cycle", {31'h0, m_busy}, 1);
      end
      data = (k < 17) ? b2[k] : 8'h00;
      if (!m_cs_n && fall_k < 0) fall_k = k;
    end
    chk("b2b_cs_fall_cycle", fall_k, 18);
    wait_done(700, "wait_done_b2b_second");
    repeat (5) @(negedge clk);

    // Reset in the middle of SHIFT, then a clean burst.
    for (int i = 0; i < 17; i++) b[i] = 8'h40 + 8'(i);
    send_burst(b, 2);
    wait_rise(40, 600, "reach_mid_shift");
    @(negedge clk); #2; rst = 1'b1;
    #1;
    chk("midrst_cs_n", {31'h0, cs2}, 1);   chk("midrst_sclk", {31'h0, sclk2}, 0);
    chk("midrst_mosi", {31'h0, mosi2}, 0); chk("midrst_busy", {31'h0, busy2}, 0);
    sb_q.delete();
    xfer_q.delete();
    repeat (3) @(negedge clk);
    #2; rst = 1'b0;
    for (int i = 0; i < 17; i++) b[i] = 8'h9F - 8'(i);
    send_burst(b, 2);
    wait_done(700, "wait_done_after_reset");
    repeat (5) @(negedge clk);

    chk("scoreboard_bytes_left", sb_q.size(), 0);
    chk("scoreboard_transfers_left", xfer_q.size(), 0);
    chk("dropped_total", drop_cnt, 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
